// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer with retired-instruction counter.
// Define CORE_CTRL_TRAP_EN to send illegal opcodes to a one-cycle TRAP state instead of a NOP retire.
module core_ctrl #(
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt,
  input  logic                     imem_ack,
  input  logic                     dmem_ack,
  input  logic [6:0]               opcode,
  input  logic                     wb_reg,
  input  logic                     wb_csr,
  input  logic                     br_cond,
  output logic                     imem_req,
  output logic                     ir_we,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic                     alu_we,
  output logic                     rf_we,
  output logic                     csr_we,
  output logic                     pc_we,
  output logic                     br_taken,
  output logic                     trap,
  output logic                     busy,
  output logic [INSTRET_WIDTH-1:0] instret
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  state_e                   state_q, state_d;
  logic                     br_taken_q, br_taken_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic                     is_load, is_store, is_branch, is_mem, legal;
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_mem    = is_load | is_store;
  assign legal     = is_mem | is_branch | (opcode == OP_SYSTEM) | (opcode == OP_OP) |
                     (opcode == OP_IMM) | (opcode == OP_LUI) | (opcode == OP_AUIPC) |
                     (opcode == OP_JAL) | (opcode == OP_JALR);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      br_taken_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      br_taken_q <= br_taken_d;
      instret_q  <= instret_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = halt ? IDLE : FETCH;
      FETCH:    state_d = imem_ack ? DECODE : FETCH;
`ifdef CORE_CTRL_TRAP_EN
      DECODE:   state_d = legal ? EXEC : TRAP;
`else
      DECODE:   state_d = legal ? EXEC : WB;
`endif
      EXEC:     state_d = is_mem ? MEM : WB;
      MEM:      state_d = dmem_ack ? WB : MEM;
      WB, TRAP: state_d = halt ? IDLE : FETCH;
      default:  state_d = IDLE;
    endcase
  end
  // br_taken survives until the next fetch so the PC mux sees it during WB
  always_comb begin
    br_taken_d = (state_d == FETCH) ? 1'b0 :
                 (state_q == EXEC && is_branch) ? br_cond : br_taken_q;
    instret_d  = instret_q + INSTRET_WIDTH'(state_q == WB);
  end
  always_comb begin
    imem_req = state_q == FETCH;
    ir_we    = (state_q == FETCH) & imem_ack;
    dmem_req = state_q == MEM;
    dmem_we  = (state_q == MEM) & is_store;
    alu_we   = state_q == EXEC;
    rf_we    = (state_q == WB) & legal & wb_reg & ~is_store & ~is_branch;
    csr_we   = (state_q == WB) & legal & wb_csr;
    pc_we    = (state_q == WB) | (state_q == TRAP);
    br_taken = br_taken_q;
`ifdef CORE_CTRL_TRAP_EN
    trap     = state_q == TRAP;
`else
    trap     = 1'b0;
`endif
    busy     = state_q != IDLE;
    instret  = instret_q;
  end
endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the TinyRisc-V core. It steps each instruction through fetch, decode, execute, optional memory access and write-back. It runs the valid/ack handshakes to instruction and data memory, and gates the register-file, CSR and PC write enables that the decoder only qualifies. It also keeps a retired-instruction counter.

## Interface
Parameters:
- INSTRET_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- halt  input  1  when high, no new fetch is started.
- imem_ack  input  1  instruction memory has returned `code` this cycle.
- dmem_ack  input  1  data memory has completed the load or store this cycle.
- opcode  input  7  `code[6:0]` of the latched instruction.
- wb_reg  input  1  decoder says the instruction writes rd.
- wb_csr  input  1  decoder says the instruction is SYSTEM/CSR.
- br_cond  input  1  ALU compare result for BRANCH, valid in EXEC.
- imem_req  output  1  fetch request.
- ir_we  output  1  latch `code` into the instruction register.
- dmem_req  output  1  data request.
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1.
- alu_we  output  1  register the ALU result.
- rf_we  output  1  register-file write enable.
- csr_we  output  1  CSR write enable.
- pc_we  output  1  PC update enable.
- br_taken  output  1  PC mux takes the branch target (held through WB).
- trap  output  1  illegal-instruction pulse (present only with the macro).
- busy  output  1  state is not IDLE.
- instret  output  INSTRET_WIDTH  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, and TRAP (TRAP only with the macro). Encoded in 3 bits.
- IDLE -> FETCH when halt=0; otherwise stay in IDLE.
- FETCH: imem_req=1 and held until imem_ack. On the imem_ack cycle ir_we=1 and next state is DECODE.
- DECODE: one cycle. Opcode classes:
  - LOAD = 0000011, STORE = 0100011, BRANCH = 1100011, SYSTEM = 1110011.
  - Legal set is those four plus OP, OP-IMM, LUI, AUIPC, JAL and JALR.
  - Illegal opcode -> TRAP (macro set) or is handled per Configuration; otherwise -> EXEC.
- EXEC: alu_we=1 for one cycle. If BRANCH, capture br_cond into br_taken. Next state is MEM for LOAD/STORE, else WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - Both are held until dmem_ack, then next state is WB.
  - A LOAD with dmem_ack and wb_reg=1 goes to WB, which writes rd.
- WB: one cycle.
  - rf_we = wb_reg & (opcode ≠ STORE, BRANCH).
  - csr_we = wb_csr.
  - pc_we = 1; instret increments.
  - Next state is FETCH if halt=0, else IDLE.
- br_taken clears when the state enters FETCH.
- instret: modulo 2^INSTRET_WIDTH; all-ones wraps to 0.
- halt is sampled only in IDLE and WB. An instruction in flight always completes.
- Each WB cycle has at most one rf_we, one csr_we and one pc_we pulse.
- dmem_ack outside MEM and imem_ack outside FETCH are ignored.

## Timing
- Reset (async assert):
  - state=IDLE.
  - All outputs 0: imem_req, ir_we, dmem_req, dmem_we, alu_we, rf_we, csr_we, pc_we, br_taken, trap, busy = 0; instret = 0.
- Reset in mid-operation aborts immediately; the pending memory request drops in the same cycle.
- State is registered. Outputs decode from state plus the ack inputs; ir_we is combinational on imem_ack.
- Minimum latency with zero-wait memory (ack in the first request cycle):
  - Non-memory instruction: FETCH, DECODE, EXEC, WB = 4 cycles.
  - Load or store: 5 cycles.
  - Each memory wait cycle adds 1.
- pc_we rises in the WB cycle. imem_req rises the next cycle.

## Configuration
- CORE_CTRL_TRAP_EN defined:
  - An illegal opcode goes DECODE -> TRAP.
  - TRAP lasts one cycle: trap=1, pc_we=1; rf_we, csr_we and alu_we stay 0; instret does not increment.
  - Next state is FETCH, or IDLE if halt=1.
- CORE_CTRL_TRAP_EN undefined:
  - The trap port is tied to 0.
  - An illegal opcode goes DECODE -> WB as a NOP: pc_we=1, rf_we=0, csr_we=0, instret increments.

## Test plan
- Reset, release with halt=0, imem_ack immediate, code 0x00500093 (ADDI x1,x0,5) -> imem_req high at cycle 1; rf_we=1, pc_we=1 at cycle 4; instret=1.
- LW 0x0000A103 with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 for exactly 3 cycles; rf_we in the cycle after ack; total 7 cycles.
- SW 0x0020A023 -> dmem_we=1 during MEM; rf_we stays 0 in WB; pc_we=1.
- BEQ with br_cond=1, then BNE with br_cond=0 -> br_taken=1 through WB on the first, 0 on the second; rf_we=0 on both.
- Code 0x00000000:
  - with CORE_CTRL_TRAP_EN -> trap pulse of 1 cycle, instret unchanged;
  - without -> NOP, instret+1.
- Preload instret=0xFFFFFFFF via a forced retire count, retire one instruction -> instret=0.
- Assert rst_n low during MEM -> dmem_req drops the same cycle, busy=0.
- halt=1 during EXEC -> WB completes, then IDLE.
